cpu_multicycle: RTL and testbench
=================================

CPU_MULTICYCLE -- requirements
Module: cpu_multicycle

Interface
REQ-001 Parameter DATA_WIDTH, default 32: register, ALU and data-bus width, 16 or more.
REQ-002 Parameter NREGS, default 16: register count, 2..16, with r0 reading as zero.
REQ-003 Parameter CODE_WORDS, default 512: instruction memory depth; PC width PW = clog2(CODE_WORDS).
REQ-004 Parameter DATA_WORDS, default 512: data memory depth; address width AW = clog2(DATA_WORDS).
REQ-005 Clocking/reset (already decided): one clock; reset is synchronous and active-high.
REQ-006 clk  in  1  sole clock; all state updates on its rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 run  in  1  fetch enable; sampled only in FETCH.
REQ-009 imem_addr  out  PW  instruction address, equal to pc.
REQ-010 imem_rdata  in  32  instruction word; valid one cycle after imem_addr (synchronous ROM).
REQ-011 dmem_addr  out  AW  data address.
REQ-012 dmem_wdata  out  DATA_WIDTH  store data.
REQ-013 dmem_we  out  1  one-cycle write strobe.
REQ-014 dmem_rdata  in  DATA_WIDTH  load data; valid one cycle after dmem_addr.
REQ-015 retire  out  1  one-cycle pulse per completed instruction.
REQ-016 halted  out  1  high while in HALT.
REQ-017 illegal  out  1  one-cycle pulse on an undefined opcode.
REQ-018 debug_pc  out  PW  current pc.
REQ-019 led  out  1  pc[1].

Function
REQ-020 Encoding: [31:28] op; [27:24] rd; [23:20] rn; [19:16] rm; [15:0] imm, sign-extended to DATA_WIDTH.
REQ-021 Register indices >= NREGS shall read as zero, and writes to them shall be discarded.
REQ-022 Opcodes:
- 0 NOP
- 1 ADDI: rd = rn + imm
- 2 ADD: rd = rn + rm
- 3 SUB: rd = rn - rm
- 4 LDR: rd = mem[rn + imm]
- 5 STR: mem[rn + imm] = rd
- 6 B: pc = pc + 1 + imm
- 7 BEQZ: branch as B if rn == 0
- 8 HALT
- 9..15: illegal, executed as NOP
REQ-023 All arithmetic shall be modulo 2^DATA_WIDTH; no flags are kept.
REQ-024 The data address shall be the low AW bits of the sum.
REQ-025 Branch targets shall be computed modulo CODE_WORDS.
REQ-026 Sequential pc increment shall wrap from CODE_WORDS-1 to 0.
REQ-027 FSM states: FETCH, DECODE, EXEC, MEM, WB, HALT.
REQ-028 FETCH: if run=1, go to DECODE; else stay in FETCH with no state change.
REQ-029 DECODE: latch imem_rdata into ir; latch operands rn, rm and rd; go to EXEC.
REQ-030 EXEC: register the ALU result; update pc (pc+1, or the taken target); pulse illegal if applicable. Next state:
- B, BEQZ, NOP, illegal: FETCH with retire=1
- HALT: HALT with retire=1
- LDR, STR: MEM
- others: WB
REQ-031 MEM: drive dmem_addr = result.
- STR: dmem_we=1, dmem_wdata=rd, retire=1, next FETCH.
- LDR: next WB.
REQ-032 WB: write the result (or dmem_rdata for LDR) to rd; retire=1; next FETCH.
REQ-033 Cycles per instruction:
- B/BEQZ/NOP/HALT: 3
- ADD/ADDI/SUB/STR: 4
- LDR: 5
REQ-034 An instruction whose source register is the previous instruction's rd shall see the written value (no hazard, since the design is not pipelined).
REQ-035 HALT shall be sticky: no fetch, no writes, and pc frozen until reset.
REQ-036 dmem_we shall be asserted only in MEM for STR, and never for two consecutive cycles.
REQ-037 Register writes shall occur only in WB.

Reset
REQ-038 reset=1 shall force on the next edge:
- state FETCH
- pc = 0
- all outputs low / zero
REQ-039 Register file contents shall be cleared to zero on reset.
REQ-040 A reset in any state shall abort the instruction in flight with no register write and no dmem_we.
REQ-041 Reset shall take priority over run and over HALT.

Verification
REQ-042 ADDI r1,r0,5 then ADDI r1,r1,-7: r1 = 2^DATA_WIDTH - 2; retire pulses at cycles 4 and 8 after reset release.
REQ-043 ADDI r2,r0,0x1234; STR r2,[r0+3]; LDR r3,[r0+3]: dmem_we once with addr 3, data 0x1234; r3 = 0x1234.
REQ-044 BEQZ r0,+2 at pc 0 -> pc becomes 3.
REQ-045 B -1 at pc CODE_WORDS-1 -> pc stays at CODE_WORDS-1.
REQ-046 B +1 at pc CODE_WORDS-1 -> pc becomes 1.
REQ-047 HALT at pc 4: halted=1, pc = 5, no further imem activity for 20 cycles.
REQ-048 Reset asserted during HALT -> resume from pc 0.
REQ-049 Opcode 0xF: illegal pulses once, the instruction retires, and register state is unchanged.
REQ-050 run=0 for 10 cycles in FETCH -> no pc change.
REQ-051 Reset asserted in the MEM cycle of a STR -> dmem_we stays 0.

Source files
------------

// File: rtl/cpu_multicycle.sv
// rtl/cpu_multicycle.sv - multicycle CPU core sequencing FETCH/DECODE/EXEC/MEM/WB/HALT
module cpu_multicycle #(
    parameter int  DATA_WIDTH = 32,
    parameter int  NREGS      = 16,
    parameter int  CODE_WORDS = 512,
    parameter int  DATA_WORDS = 512,
    localparam int PW         = $clog2(CODE_WORDS),
    localparam int AW         = $clog2(DATA_WORDS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  run,
    output logic [PW-1:0]         imem_addr,
    input  logic [31:0]           imem_rdata,
    output logic [AW-1:0]         dmem_addr,
    output logic [DATA_WIDTH-1:0] dmem_wdata,
    output logic                  dmem_we,
    input  logic [DATA_WIDTH-1:0] dmem_rdata,
    output logic                  retire,
    output logic                  halted,
    output logic                  illegal,
    output logic [PW-1:0]         debug_pc,
    output logic                  led
);
    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_ADDI = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_SUB  = 4'd3;
    localparam logic [3:0] OP_LDR  = 4'd4;
    localparam logic [3:0] OP_STR  = 4'd5;
    localparam logic [3:0] OP_B    = 4'd6;
    localparam logic [3:0] OP_BEQZ = 4'd7;
    localparam logic [3:0] OP_HALT = 4'd8;

    state_t                state_q, state_d;
    logic [PW-1:0]         pc_q, pc_d, pc_inc, br_target;
    logic [3:0]            op_q, op_d, rd_idx_q, rd_idx_d;
    logic [15:0]           imm_q, imm_d;
    logic [DATA_WIDTH-1:0] rn_val_q, rn_val_d, rm_val_q, rm_val_d, rd_val_q, rd_val_d;
    logic [DATA_WIDTH-1:0] result_q, result_d, imm_ext;
    logic [DATA_WIDTH-1:0] rf_q [NREGS];
    logic [DATA_WIDTH-1:0] rf_d [NREGS];
    logic                  retire_q, retire_d, illegal_q, illegal_d, dmem_we_q, dmem_we_d;
    logic [3:0]            f_rd, f_rn, f_rm;
    int                    br_sum;

    assign f_rd    = imem_rdata[27:24];
    assign f_rn    = imem_rdata[23:20];
    assign f_rm    = imem_rdata[19:16];
    assign imm_ext = {{(DATA_WIDTH-16){imm_q[15]}}, imm_q};
    assign pc_inc  = (pc_q == PW'(CODE_WORDS - 1)) ? '0 : pc_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        op_d      = op_q;
        rd_idx_d  = rd_idx_q;
        imm_d     = imm_q;
        rn_val_d  = rn_val_q;
        rm_val_d  = rm_val_q;
        rd_val_d  = rd_val_q;
        result_d  = result_q;
        rf_d      = rf_q;
        retire_d  = 1'b0;
        illegal_d = 1'b0;
        dmem_we_d = 1'b0;
        // Branch target wraps modulo CODE_WORDS, including backward wrap below zero.
        br_sum = (int'(pc_q) + 1 + int'($signed(imm_q))) % CODE_WORDS;
        if (br_sum < 0) br_sum = br_sum + CODE_WORDS;
        br_target = PW'(br_sum);

        case (state_q)
            S_FETCH: if (run) state_d = S_DECODE;
            S_DECODE: begin
                op_d     = imem_rdata[31:28];
                rd_idx_d = f_rd;
                imm_d    = imem_rdata[15:0];
                rn_val_d = (f_rn != 4'd0 && int'(f_rn) < NREGS) ? rf_q[f_rn] : '0;
                rm_val_d = (f_rm != 4'd0 && int'(f_rm) < NREGS) ? rf_q[f_rm] : '0;
                rd_val_d = (f_rd != 4'd0 && int'(f_rd) < NREGS) ? rf_q[f_rd] : '0;
                state_d  = S_EXEC;
            end
            S_EXEC: begin
                pc_d = pc_inc;
                case (op_q)
                    OP_NOP:  begin retire_d = 1'b1; state_d = S_FETCH; end
                    OP_ADDI: begin result_d = rn_val_q + imm_ext;  state_d = S_WB; end
                    OP_ADD:  begin result_d = rn_val_q + rm_val_q; state_d = S_WB; end
                    OP_SUB:  begin result_d = rn_val_q - rm_val_q; state_d = S_WB; end
                    OP_LDR, OP_STR: begin
                        result_d  = rn_val_q + imm_ext;
                        dmem_we_d = (op_q == OP_STR);
                        state_d   = S_MEM;
                    end
                    OP_B: begin
                        pc_d     = br_target;
                        retire_d = 1'b1;
                        state_d  = S_FETCH;
                    end
                    OP_BEQZ: begin
                        if (rn_val_q == '0) pc_d = br_target;
                        retire_d = 1'b1;
                        state_d  = S_FETCH;
                    end
                    OP_HALT: begin retire_d = 1'b1; state_d = S_HALT; end
                    default: begin
                        illegal_d = 1'b1;
                        retire_d  = 1'b1;
                        state_d   = S_FETCH;
                    end
                endcase
            end
            S_MEM: begin
                if (op_q == OP_STR) begin
                    retire_d = 1'b1;
                    state_d  = S_FETCH;
                end else begin
                    state_d = S_WB;
                end
            end
            S_WB: begin
                if (rd_idx_q != 4'd0 && int'(rd_idx_q) < NREGS)
                    rf_d[rd_idx_q] = (op_q == OP_LDR) ? dmem_rdata : result_q;
                retire_d = 1'b1;
                state_d  = S_FETCH;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            pc_q      <= '0;
            op_q      <= '0;
            rd_idx_q  <= '0;
            imm_q     <= '0;
            rn_val_q  <= '0;
            rm_val_q  <= '0;
            rd_val_q  <= '0;
            result_q  <= '0;
            retire_q  <= 1'b0;
            illegal_q <= 1'b0;
            dmem_we_q <= 1'b0;
            for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            op_q      <= op_d;
            rd_idx_q  <= rd_idx_d;
            imm_q     <= imm_d;
            rn_val_q  <= rn_val_d;
            rm_val_q  <= rm_val_d;
            rd_val_q  <= rd_val_d;
            result_q  <= result_d;
            retire_q  <= retire_d;
            illegal_q <= illegal_d;
            dmem_we_q <= dmem_we_d;
            rf_q      <= rf_d;
        end
    end

    // The strobe is high for the whole MEM cycle; a reset raised mid-cycle must still kill the write.
    assign dmem_we    = dmem_we_q & ~reset;
    assign dmem_addr  = result_q[AW-1:0];
    assign dmem_wdata = rd_val_q;
    assign imem_addr  = pc_q;
    assign debug_pc   = pc_q;
    assign led        = pc_q[1];
    assign retire     = retire_q;
    assign illegal    = illegal_q;
    assign halted     = (state_q == S_HALT);
endmodule

// File: tb/tb_cpu_multicycle.sv
// tb/tb_cpu_multicycle.sv - scoreboard bench for cpu_multicycle with directed programs
module tb_cpu_multicycle;
    logic        clk = 1'b0;
    logic        reset, run;
    logic [8:0]  imem_addr, debug_pc, dmem_addr;
    logic [31:0] imem_rdata, dmem_wdata, dmem_rdata;
    logic        dmem_we, retire, halted, illegal, led;

    logic [31:0] imem [512];
    logic [31:0] dmem [512];
    int          cyc, checks, errors, illegal_cnt;

    typedef struct { int pc; int cyc; } ret_t;
    typedef struct { int addr; longint data; } wr_t;
    ret_t ret_q[$];
    wr_t  wr_q[$];
    ret_t re;
    wr_t  we_e;

    cpu_multicycle dut (
        .clk(clk), .reset(reset), .run(run),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_we(dmem_we),
        .dmem_rdata(dmem_rdata), .retire(retire), .halted(halted),
        .illegal(illegal), .debug_pc(debug_pc), .led(led)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        imem_rdata <= imem[imem_addr];
        if (dmem_we) dmem[dmem_addr] <= dmem_wdata;
        dmem_rdata <= dmem[dmem_addr];
        cyc <= reset ? 0 : cyc + 1;
    end

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && retire) begin
            if (ret_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL retire_unexpected: got retire at pc %0d cyc %0d, required none", debug_pc, cyc);
            end else begin
                re = ret_q.pop_front();
                check("retire_pc", longint'(debug_pc), re.pc);
                check("retire_cycle", cyc, re.cyc);
                check("led", longint'(led), (re.pc >> 1) & 1);
            end
        end
        if (dmem_we) begin
            if (wr_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL write_unexpected: got write addr %0d data 0x%0h, required none", dmem_addr, dmem_wdata);
            end else begin
                we_e = wr_q.pop_front();
                check("write_addr", longint'(dmem_addr), we_e.addr);
                check("write_data", longint'(dmem_wdata), we_e.data);
            end
        end
        if (!reset && illegal) illegal_cnt++;
    end

    function automatic logic [31:0] enc(input int op, input int rd, input int rn, input int rm, input int imm);
        return {op[3:0], rd[3:0], rn[3:0], rm[3:0], imm[15:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_ret(input int pc, input int c);
        ret_t r;
        r.pc = pc; r.cyc = c;
        ret_q.push_back(r);
    endtask

    task automatic exp_wr(input int a, input longint d);
        wr_t w;
        w.addr = a; w.data = d;
        wr_q.push_back(w);
    endtask

    task automatic clear_imem();
        for (int i = 0; i < 512; i++) imem[i] = 32'h0;
    endtask

    task automatic release_run();
        tick();
        reset = 1'b0;
        run   = 1'b1;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while ((ret_q.size() != 0 || wr_q.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        check(name, ret_q.size() + wr_q.size(), 0);
        ret_q.delete();
        wr_q.delete();
    endtask

    task automatic hold_halt(input string name, input int pc);
        int moved;
        moved = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (imem_addr != 9'(pc) || !halted) moved++;
        end
        check({name, "_idle"}, moved, 0);
        check({name, "_pc"}, longint'(debug_pc), pc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    initial begin
        checks = 0; errors = 0; illegal_cnt = 0; cyc = 0;
        reset = 1'b1; run = 1'b0;
        clear_imem();
        for (int i = 0; i < 512; i++) dmem[i] = 32'h0;
        tick(); tick();
        check("rst_imem_addr", longint'(imem_addr), 0);
        check("rst_debug_pc", longint'(debug_pc), 0);
        check("rst_dmem_addr", longint'(dmem_addr), 0);
        check("rst_dmem_wdata", longint'(dmem_wdata), 0);
        check("rst_dmem_we", longint'(dmem_we), 0);
        check("rst_retire", longint'(retire), 0);
        check("rst_halted", longint'(halted), 0);
        check("rst_illegal", longint'(illegal), 0);
        check("rst_led", longint'(led), 0);

        // ADDI chain to a negative result, observed through a store
        imem[0] = enc(1, 1, 0, 0, 5);
        imem[1] = enc(1, 1, 1, 0, -7);
        imem[2] = enc(5, 1, 0, 0, 10);
        imem[3] = enc(8, 0, 0, 0, 0);
        exp_ret(1, 4); exp_ret(2, 8); exp_ret(3, 12); exp_ret(4, 15);
        exp_wr(10, 64'hFFFF_FFFE);
        release_run();
        wait_drain("t1_drain", 60);
        check("t1_halted", longint'(halted), 1);
        hold_halt("t1_halt", 4);

        // reset out of HALT, then store/load round trip
        reset = 1'b1;
        tick();
        check("halt_reset_pc", longint'(debug_pc), 0);
        check("halt_reset_halted", longint'(halted), 0);
        clear_imem();
        imem[0] = enc(1, 2, 0, 0, 16'h1234);
        imem[1] = enc(5, 2, 0, 0, 3);
        imem[2] = enc(4, 3, 0, 0, 3);
        imem[3] = enc(5, 3, 0, 0, 4);
        imem[4] = enc(8, 0, 0, 0, 0);
        exp_ret(1, 4); exp_ret(2, 8); exp_ret(3, 13); exp_ret(4, 17); exp_ret(5, 20);
        exp_wr(3, 64'h1234); exp_wr(4, 64'h1234);
        release_run();
        wait_drain("t2_drain", 60);
        hold_halt("t2_halt", 5);

        // BEQZ taken, branch to top of code, B -1 wrapping back onto itself, then run=0
        reset = 1'b1;
        clear_imem();
        imem[0]   = enc(7, 0, 0, 0, 2);
        imem[3]   = enc(6, 0, 0, 0, 507);
        imem[511] = enc(6, 0, 0, 0, -1);
        exp_ret(3, 3); exp_ret(511, 6); exp_ret(511, 9);
        release_run();
        repeat (9) tick();
        run = 1'b0;
        repeat (10) tick();
        check("run0_pc", longint'(debug_pc), 511);
        check("run0_imem_addr", longint'(imem_addr), 511);
        wait_drain("t3_drain", 2);

        // B +1 at the last code word wraps to pc 1
        reset = 1'b1;
        clear_imem();
        imem[0]   = enc(6, 0, 0, 0, 510);
        imem[511] = enc(6, 0, 0, 0, 1);
        imem[1]   = enc(8, 0, 0, 0, 0);
        exp_ret(511, 3); exp_ret(1, 6); exp_ret(2, 9);
        release_run();
        wait_drain("t3b_drain", 40);
        check("t3b_halted", longint'(halted), 1);

        // illegal opcode leaves registers alone; BEQZ not taken
        reset = 1'b1;
        clear_imem();
        imem[0] = enc(1, 5, 0, 0, 1);
        imem[1] = enc(15, 5, 0, 0, 16'h77);
        imem[2] = enc(7, 0, 5, 0, 5);
        imem[3] = enc(5, 5, 0, 0, 7);
        imem[4] = enc(8, 0, 0, 0, 0);
        exp_ret(1, 4); exp_ret(2, 7); exp_ret(3, 10); exp_ret(4, 14); exp_ret(5, 17);
        exp_wr(7, 1);
        tick();
        illegal_cnt = 0;
        release_run();
        wait_drain("t4_drain", 60);
        check("illegal_pulses", illegal_cnt, 1);

        // reset during the MEM cycle of a store aborts it; registers come back cleared
        reset = 1'b1;
        clear_imem();
        imem[0] = enc(1, 6, 0, 0, 16'h55);
        imem[1] = enc(5, 6, 0, 0, 9);
        exp_ret(1, 4);
        release_run();
        repeat (7) tick();
        reset = 1'b1;
        #1;
        check("mem_reset_we", longint'(dmem_we), 0);
        tick();
        check("mem_reset_pc", longint'(debug_pc), 0);
        imem[0] = enc(5, 6, 0, 0, 9);
        imem[1] = enc(8, 0, 0, 0, 0);
        exp_ret(1, 4); exp_ret(2, 7);
        exp_wr(9, 0);
        release_run();
        wait_drain("t5_drain", 40);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
